// File: rtl/e1ofn_sync_transmitter.sv
// Clocked valid/ready stream to 4-phase e1ofN rail bundle sender with a small symbol FIFO.
// Optional protocol monitor (sticky err_proto plus $error) enabled by E1OFN_TX_PROTOCOL_CHECK_EN.
module e1ofn_sync_transmitter #(
  parameter int BASE        = 4,
  parameter int NUM_BITS    = 3,
  parameter int DEPTH       = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM_BITS-1:0] in_data,
  output logic [0:BASE-1]     nodes,
  input  logic                enable,
  output logic                busy,
  output logic                err_range,
  output logic                err_proto
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = (BASE > 1) ? $clog2(BASE) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    NULLW = 2'd2
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   enable_s;

  logic [SW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            head_vld;
  logic [SW-1:0]   head;
  logic            push, enq, pop, in_range;
  logic [0:BASE-1] nodes_next;

  always_ff @(posedge CLK) begin
    if (RESET) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], enable};
  end

  assign enable_s = sync_q[SYNC_STAGES-1];

  assign in_range = !in_data[NUM_BITS-1] && (in_data <= NUM_BITS'(BASE - 1));
  assign in_ready = !RESET && (count != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign enq      = push && in_range;
  assign head     = mem[rd_ptr];
  assign busy     = !RESET && ((count != '0) || (state != IDLE));

  always_ff @(posedge CLK) begin
    if (enq) mem[wr_ptr] <= in_data[SW-1:0];
  end

  // head_vld lags count by one cycle so a fresh symbol drives two edges after its push
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      head_vld <= 1'b0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      head_vld <= (count != '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET)                err_range <= 1'b0;
    else if (push && !in_range) err_range <= 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      nodes <= '0;
    end else begin
      state <= state_next;
      nodes <= nodes_next;
    end
  end

  always_comb begin
    state_next = state;
    nodes_next = nodes;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        nodes_next = '0;
        if (enable_s && head_vld) begin
          nodes_next[head] = 1'b1;
          state_next       = DATA;
        end
      end
      DATA: begin
        if (!enable_s) begin
          nodes_next = '0;
          pop        = 1'b1;
          state_next = NULLW;
        end
      end
      NULLW: begin
        nodes_next = '0;
        if (enable_s) state_next = IDLE;
      end
      default: begin
        nodes_next = '0;
        state_next = IDLE;
      end
    endcase
  end

`ifdef E1OFN_TX_PROTOCOL_CHECK_EN
  logic enable_s_d;
  logic proto_hit;

  // an acknowledge falling while data waits but no rail is up is a receiver fault
  assign proto_hit = ((state == IDLE) && enable_s_d && !enable_s && (count != '0)) ||
                     ((state == DATA) && !$onehot(nodes));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      enable_s_d <= 1'b0;
      err_proto  <= 1'b0;
    end else begin
      enable_s_d <= enable_s;
      if (proto_hit) begin
        err_proto <= 1'b1;
        if (!err_proto) $error("%m: e1ofN protocol violation");
      end
    end
  end
`else
  assign err_proto = 1'b0;
`endif

endmodule

// File: tb/tb_e1ofn_sync_transmitter.sv
// Self-checking bench for e1ofn_sync_transmitter: directed steps plus a randomized
// stream against a queue model of accepted symbols acting as the asynchronous receiver.
module tb_e1ofn_sync_transmitter;
  localparam int BASE        = 4;
  localparam int NUM_BITS    = 3;
  localparam int DEPTH       = 2;
  localparam int SYNC_STAGES = 2;

`ifdef E1OFN_TX_PROTOCOL_CHECK_EN
  localparam logic PROTO_ON = 1'b1;
`else
  localparam logic PROTO_ON = 1'b0;
`endif

  logic                CLK = 1'b0;
  logic                RESET;
  logic                in_valid;
  logic                in_ready;
  logic [NUM_BITS-1:0] in_data;
  logic [0:BASE-1]     nodes;
  logic                enable;
  logic                busy;
  logic                err_range;
  logic                err_proto;

  int checks = 0;
  int errors = 0;

  logic [NUM_BITS-1:0] tx_q[$];
  int                  exp_q[$];
  logic                exp_err_range;
  bit                  got;
  int                  dly;

  always #5 CLK = ~CLK;

  e1ofn_sync_transmitter #(
    .BASE(BASE), .NUM_BITS(NUM_BITS), .DEPTH(DEPTH), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .nodes(nodes), .enable(enable), .busy(busy),
    .err_range(err_range), .err_proto(err_proto)
  );

  function automatic logic [0:BASE-1] onehot(input int s);
    logic [0:BASE-1] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

  function automatic int sval(input logic [NUM_BITS-1:0] d);
    return int'($signed(d));
  endfunction

  function automatic int rand_sym();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 8)  return r % BASE;
    if (r == 8) return BASE;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    if (tx_q.size() > 0) begin
      in_valid = 1'b1;
      in_data  = tx_q[0];
    end else begin
      in_valid = 1'b0;
      in_data  = '0;
    end
  endtask

  task automatic send(input int v);
    tx_q.push_back(NUM_BITS'(v));
    drive();
  endtask

  // one clock; the model accepts the head symbol when the handshake completed at this edge
  task automatic cycle();
    bit fire, rst_pre;
    int v;
    fire    = in_valid && in_ready;
    rst_pre = RESET;
    @(posedge CLK);
    #1;
    if (rst_pre) begin
      exp_q.delete();
      exp_err_range = 1'b0;
    end else if (fire) begin
      v = sval(tx_q[0]);
      if (v >= 0 && v < BASE) exp_q.push_back(v);
      else exp_err_range = 1'b1;
      void'(tx_q.pop_front());
    end
    drive();
    chk("onehot0", 32'($onehot0(nodes)), 1);
    chk("err_range", err_range, exp_err_range);
  endtask

  task automatic rx_rise(input string tag);
    int n;
    n      = 0;
    enable = 1'b1;
    while (nodes === '0 && n < 40) begin
      cycle();
      n++;
    end
    chk({tag, "_rise"}, nodes !== '0, 1);
    if (exp_q.size() > 0) chk({tag, "_sym"}, nodes, onehot(exp_q.pop_front()));
    else chk({tag, "_sym_unexpected"}, nodes, 0);
  endtask

  task automatic rx_fall(input string tag);
    int n;
    n      = 0;
    enable = 1'b0;
    while (nodes !== '0 && n < 40) begin
      cycle();
      n++;
    end
    chk({tag, "_fall"}, nodes, 0);
  endtask

  task automatic rx_step();
    if (!got) begin
      if (enable && nodes !== '0) begin
        if (exp_q.size() > 0) chk("rand_sym", nodes, onehot(exp_q.pop_front()));
        else chk("rand_unexpected", nodes, 0);
        got = 1'b1;
        dly = int'($urandom_range(0, 3));
      end
    end else if (enable) begin
      if (dly == 0) begin
        enable = 1'b0;
        dly    = int'($urandom_range(0, 3));
      end else dly--;
    end else if (nodes === '0) begin
      if (dly == 0) begin
        enable = 1'b1;
        got    = 1'b0;
      end else dly--;
    end
  endtask

  initial begin
    int n;
    RESET         = 1'b1;
    enable        = 1'b1;
    in_valid      = 1'b0;
    in_data       = '0;
    got           = 1'b0;
    dly           = 0;
    exp_err_range = 1'b0;

    // reset with live inputs
    send(2);
    repeat (3) cycle();
    chk("reset_nodes", nodes, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_err_proto", err_proto, 0);
    RESET = 1'b0;
    tx_q.delete();
    drive();
    #1;
    chk("release_in_ready", in_ready, 1);
    for (int i = 0; i < SYNC_STAGES + 2; i++) begin
      cycle();
      chk("release_no_rail", nodes, 0);
    end

    // single symbol, cycle-exact latency
    send(2);
    cycle();
    cycle();
    chk("single_t1", nodes, 0);
    cycle();
    chk("single_t2", nodes, 4'b0010);
    chk("single_busy", busy, 1);
    void'(exp_q.pop_front());
    enable = 1'b0;
    repeat (2) begin
      cycle();
      chk("single_hold", nodes, 4'b0010);
    end
    cycle();
    chk("single_fall", nodes, 0);
    chk("single_empty_ready", in_ready, 1);
    chk("single_busy_nullw", busy, 1);
    enable = 1'b1;
    repeat (2) cycle();
    chk("single_busy_wait", busy, 1);
    cycle();
    chk("single_idle_busy", busy, 0);

    // backpressure stream
    enable = 1'b0;
    repeat (4) cycle();
    send(0); send(3); send(1); send(2);
    cycle();
    chk("bp_ready_1", in_ready, 1);
    cycle();
    chk("bp_ready_2", in_ready, 0);
    for (int i = 0; i < 4; i++) begin
      rx_rise("bp");
      rx_fall("bp");
    end
    chk("bp_drained", exp_q.size() + tx_q.size(), 0);

    // out-of-range symbols
    send(-1); send(4); send(1);
    repeat (6) begin
      cycle();
      chk("range_no_rail", nodes, 0);
    end
    chk("range_sticky", err_range, 1);
    chk("range_queue", exp_q.size(), 1);
    rx_rise("range");
    chk("range_sym_const", nodes, 4'b0100);
    rx_fall("range");
    chk("range_sticky_after", err_range, 1);

    // reset while a rail is up
    send(3); send(0);
    repeat (3) cycle();
    rx_rise("mid");
    chk("mid_data", nodes, 4'b0001);
    RESET = 1'b1;
    cycle();
    chk("mid_nodes", nodes, 0);
    chk("mid_ready_in_reset", in_ready, 0);
    chk("mid_busy_in_reset", busy, 0);
    RESET = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("mid_no_emit", nodes, 0);
    end
    chk("mid_ready_after", in_ready, 1);
    chk("mid_busy_after", busy, 0);

    // acknowledge withdrawn while data waits in IDLE
    repeat (3) cycle();
    send(1);
    enable = 1'b0;
    repeat (5) cycle();
    chk("proto_no_rail", nodes, 0);
    chk("proto_flag", err_proto, PROTO_ON);
    rx_rise("proto");
    rx_fall("proto");

    // randomized stream with a randomly paced receiver
    enable = 1'b1;
    got    = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (tx_q.size() == 0 && $urandom_range(0, 2) == 0) send(rand_sym());
      cycle();
      rx_step();
    end
    n = 0;
    while ((exp_q.size() > 0 || tx_q.size() > 0 || got) && n < 500) begin
      cycle();
      rx_step();
      n++;
    end
    chk("rand_drained", exp_q.size() + tx_q.size() + int'(got), 0);
    repeat (5) cycle();
    chk("rand_busy", busy, 0);
    chk("rand_nodes", nodes, 0);
    chk("rand_err_proto", err_proto, PROTO_ON);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
